// File: rtl/uac_fifo_pkg.sv
// Shared types for the audio FIFO read-side sequencer.
// FIFO_DRIFT_SKIP_EN adds the drift-skip states.
package uac_fifo_pkg;

    // Fewest words that must be visible before a stereo pair may be popped.
    localparam int MIN_FILL = 2;

    typedef enum logic [3:0] {
        IDLE,
        PRIME,
        RUN,
        POP_L,
        SETTLE1,
        POP_R,
        SETTLE2
`ifdef FIFO_DRIFT_SKIP_EN
        ,
        SKIP_L,
        SKIP_S1,
        SKIP_R,
        SKIP_S2
`endif
    } state_t;

endpackage

// File: rtl/uac_sat_cnt.sv
// Saturating event counter: holds at all ones, cleared only by reset.
module uac_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/uac_fifo_rd_ctrl.sv
// Audio FIFO read sequencer: primes, pops L/R pairs per I2S request, mutes on underrun.
// Build with FIFO_DRIFT_SKIP_EN to drop a pair when the fill level runs high.
module uac_fifo_rd_ctrl
    import uac_fifo_pkg::*;
#(
    parameter int DSIZE     = 32,
    parameter int ASIZE     = 6,
    parameter int PRIME_LVL = 32,
    parameter int SKIP_LVL  = 56,
    parameter int CNT_W     = 16
) (
    input  logic             RdClock,
    input  logic             RPReset,
    input  logic             enable,
    input  logic             sample_req,
    input  logic [DSIZE-1:0] fifo_q,
    input  logic [ASIZE:0]   fifo_rd_num,
    output logic             fifo_rd_en,
    output logic [DSIZE-1:0] left_data,
    output logic [DSIZE-1:0] right_data,
    output logic             sample_valid,
    output logic             playing,
    output logic [CNT_W-1:0] underrun_cnt,
    output logic [CNT_W-1:0] skip_cnt
);

`ifdef FIFO_DRIFT_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    localparam logic [ASIZE:0] MIN_NUM   = (ASIZE+1)'(MIN_FILL);
    localparam logic [ASIZE:0] PRIME_NUM = (ASIZE+1)'(PRIME_LVL);
    localparam logic [ASIZE:0] SKIP_NUM  = (ASIZE+1)'(SKIP_LVL);

    state_t           state_q, state_d;
    logic [DSIZE-1:0] hold_q, hold_d;
    logic [DSIZE-1:0] left_q, left_d;
    logic [DSIZE-1:0] right_q, right_d;
    logic             valid_q, valid_d;

    logic fill_ok, req_run, underrun_evt, skip_evt, mute_evt;

    assign fill_ok      = (fifo_rd_num >= MIN_NUM);
    assign req_run      = (state_q == RUN) && sample_req && enable;
    assign underrun_evt = req_run && !fill_ok;
    assign skip_evt     = req_run && SKIP_EN && (fifo_rd_num >= SKIP_NUM);
    // A request in RUN with enable already low gets silence, not a pop.
    assign mute_evt     = sample_req &&
                          ((state_q == IDLE) || (state_q == PRIME) ||
                           ((state_q == RUN) && !(enable && fill_ok)));

    always_ff @(posedge RdClock or posedge RPReset) begin
        if (RPReset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable) state_d = PRIME;
            PRIME: begin
                if (!enable)
                    state_d = IDLE;
                else if (fifo_rd_num >= PRIME_NUM)
                    state_d = RUN;
            end
            RUN: begin
                if (!enable)
                    state_d = IDLE;
                else if (sample_req) begin
                    if (!fill_ok)
                        state_d = PRIME;
`ifdef FIFO_DRIFT_SKIP_EN
                    else if (skip_evt)
                        state_d = SKIP_L;
`endif
                    else
                        state_d = POP_L;
                end
            end
            POP_L:   state_d = SETTLE1;
            SETTLE1: state_d = POP_R;
            POP_R:   state_d = SETTLE2;
            SETTLE2: state_d = enable ? RUN : IDLE;
`ifdef FIFO_DRIFT_SKIP_EN
            SKIP_L:  state_d = SKIP_S1;
            SKIP_S1: state_d = SKIP_R;
            SKIP_R:  state_d = SKIP_S2;
            SKIP_S2: state_d = POP_L;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fifo_rd_en = 1'b0;
        playing    = 1'b1;
        case (state_q)
            IDLE, PRIME: playing    = 1'b0;
            POP_L, POP_R: fifo_rd_en = 1'b1;
`ifdef FIFO_DRIFT_SKIP_EN
            SKIP_L, SKIP_R: fifo_rd_en = 1'b1;
`endif
            default: fifo_rd_en = 1'b0;
        endcase
    end

    // Left is parked in hold_q so both channels change in the same cycle.
    always_comb begin
        hold_d  = hold_q;
        left_d  = left_q;
        right_d = right_q;
        valid_d = 1'b0;
        if (state_q == POP_L)
            hold_d = fifo_q;
        if (state_q == POP_R) begin
            left_d  = hold_q;
            right_d = fifo_q;
            valid_d = 1'b1;
        end else if (mute_evt) begin
            left_d  = '0;
            right_d = '0;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge RdClock or posedge RPReset) begin
        if (RPReset) begin
            hold_q  <= '0;
            left_q  <= '0;
            right_q <= '0;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            left_q  <= left_d;
            right_q <= right_d;
            valid_q <= valid_d;
        end
    end

    assign left_data    = left_q;
    assign right_data   = right_q;
    assign sample_valid = valid_q;

    uac_sat_cnt #(.CNT_W(CNT_W)) u_underrun_cnt (
        .clk_i (RdClock),
        .rst_i (RPReset),
        .inc_i (underrun_evt),
        .cnt_o (underrun_cnt)
    );

    uac_sat_cnt #(.CNT_W(CNT_W)) u_skip_cnt (
        .clk_i (RdClock),
        .rst_i (RPReset),
        .inc_i (skip_evt),
        .cnt_o (skip_cnt)
    );

endmodule

// File: tb/tb_uac_fifo_rd_ctrl.sv
// Self-checking bench for uac_fifo_rd_ctrl: directed steps plus randomized requests
// against a phase-level model; honours FIFO_DRIFT_SKIP_EN when defined.
module tb_uac_fifo_rd_ctrl;

    localparam int DSIZE     = 32;
    localparam int ASIZE     = 6;
    localparam int PRIME_LVL = 32;
    localparam int SKIP_LVL  = 56;
    localparam int CNT_W     = 3;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
`ifdef FIFO_DRIFT_SKIP_EN
    localparam bit SKIP_ON = 1'b1;
`else
    localparam bit SKIP_ON = 1'b0;
`endif

    logic             RdClock = 1'b0;
    logic             RPReset;
    logic             enable;
    logic             sample_req;
    logic [DSIZE-1:0] fifo_q;
    logic [ASIZE:0]   fifo_rd_num;
    logic             fifo_rd_en;
    logic [DSIZE-1:0] left_data;
    logic [DSIZE-1:0] right_data;
    logic             sample_valid;
    logic             playing;
    logic [CNT_W-1:0] underrun_cnt;
    logic [CNT_W-1:0] skip_cnt;

    int tests = 0;
    int fails = 0;

    // Model state: 0 = idle, 1 = priming, 2 = playing
    int mode;
    int exp_under;
    int exp_skip;

    logic [DSIZE-1:0] fifo_words[$];
    logic             pop_pending = 1'b0;

    uac_fifo_rd_ctrl #(
        .DSIZE(DSIZE), .ASIZE(ASIZE), .PRIME_LVL(PRIME_LVL),
        .SKIP_LVL(SKIP_LVL), .CNT_W(CNT_W)
    ) dut (
        .RdClock      (RdClock),
        .RPReset      (RPReset),
        .enable       (enable),
        .sample_req   (sample_req),
        .fifo_q       (fifo_q),
        .fifo_rd_num  (fifo_rd_num),
        .fifo_rd_en   (fifo_rd_en),
        .left_data    (left_data),
        .right_data   (right_data),
        .sample_valid (sample_valid),
        .playing      (playing),
        .underrun_cnt (underrun_cnt),
        .skip_cnt     (skip_cnt)
    );

    always #5 RdClock = ~RdClock;

    // Registered-output FIFO: a pop seen during a cycle takes effect at the next edge.
    always @(negedge RdClock) pop_pending <= fifo_rd_en;
    always @(posedge RdClock) begin
        if (pop_pending && fifo_words.size() > 0)
            fifo_words.delete(0);
        if (fifo_words.size() > 0)
            fifo_q <= fifo_words[0];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    function automatic int next_mode(input int m, input logic en, input logic [ASIZE:0] num);
        case (m)
            0:       return en ? 1 : 0;
            1:       return !en ? 0 : ((int'(num) >= PRIME_LVL) ? 2 : 1);
            default: return en ? 2 : 0;
        endcase
    endfunction

    // One cycle without a request; inputs were set by the caller at this negedge.
    task automatic idle_cycle();
        mode = next_mode(mode, enable, fifo_rd_num);
        @(negedge RdClock);
        check("idle_playing", playing, (mode == 2));
        check("idle_rd_en", fifo_rd_en, 1'b0);
        check("idle_valid", sample_valid, 1'b0);
        $display("[TB] cycle: en=%0b num=%0d playing=%0b", enable, fifo_rd_num, playing);
    endtask

    // One sample_req; drop_en=1 lowers enable once the pair has started.
    task automatic request(input bit drop_en);
        int               kind;
        int               last;
        int               base;
        int               pops;
        logic [DSIZE-1:0] exp_l;
        logic [DSIZE-1:0] exp_r;
        string            what;

        exp_l = '0;
        exp_r = '0;
        pops  = 0;
        if (mode == 2 && enable && int'(fifo_rd_num) >= 2)
            kind = (SKIP_ON && int'(fifo_rd_num) >= SKIP_LVL) ? 2 : 1;
        else
            kind = 0;

        if (kind == 0) begin
            last = 1;
            if (mode == 2 && enable) begin
                exp_under = sat_inc(exp_under);
                mode = 1;
                what = "underrun";
            end else begin
                mode = next_mode(mode, enable, fifo_rd_num);
                what = "mute";
            end
        end else begin
            base  = (kind == 2) ? 2 : 0;
            exp_l = fifo_words[base];
            exp_r = fifo_words[base + 1];
            last  = (kind == 2) ? 8 : 4;
            if (kind == 2) exp_skip = sat_inc(exp_skip);
            what = (kind == 2) ? "skip" : "pair";
        end

        sample_req = 1'b1;
        for (int k = 1; k <= last; k++) begin
            @(negedge RdClock);
            if (k == 1) begin
                sample_req = 1'b0;
                if (drop_en) enable = 1'b0;
            end
            if (fifo_rd_en) pops++;
            check("req_rd_en", fifo_rd_en, (kind != 0) && (k % 2 == 1) && (k < last));
            check("req_valid", sample_valid, (k == last));
            check("req_playing", playing, (kind != 0) ? 1'b1 : (mode == 2));
        end
        check("req_left", left_data, exp_l);
        check("req_right", right_data, exp_r);
        check("req_pops", pops, (kind == 0) ? 0 : ((kind == 2) ? 4 : 2));
        check("underrun_cnt", underrun_cnt, exp_under);
        check("skip_cnt", skip_cnt, exp_skip);
        $display("[TB] req %s: L=%h R=%h pops=%0d ucnt=%0d scnt=%0d",
                 what, left_data, right_data, pops, underrun_cnt, skip_cnt);
    endtask

    initial begin
        for (int i = 0; i < 320; i++)
            fifo_words.push_back((i < 8) ? DSIZE'(32'h1111 * (i + 1)) : DSIZE'($urandom));

        RPReset     = 1'b1;
        enable      = 1'b0;
        sample_req  = 1'b0;
        fifo_rd_num = '0;
        mode        = 0;
        exp_under   = 0;
        exp_skip    = 0;
        #1;
        check("rst_rd_en", fifo_rd_en, 1'b0);
        check("rst_valid", sample_valid, 1'b0);
        check("rst_playing", playing, 1'b0);
        check("rst_left", left_data, '0);
        check("rst_right", right_data, '0);
        check("rst_ucnt", underrun_cnt, '0);
        check("rst_scnt", skip_cnt, '0);
        @(negedge RdClock);
        @(negedge RdClock);
        RPReset = 1'b0;

        // Priming: playing rises only the cycle after the fill reaches 32.
        idle_cycle();
        enable = 1'b1;
        idle_cycle();
        fifo_rd_num = 31;
        idle_cycle();
        idle_cycle();
        request(1'b0);
        fifo_rd_num = 32;
        idle_cycle();
        idle_cycle();

        // Normal pair from the head of the FIFO (0x1111, 0x2222).
        fifo_rd_num = 40;
        request(1'b0);
        idle_cycle();
        idle_cycle();

        // Underrun.
        fifo_rd_num = 1;
        request(1'b0);
        idle_cycle();

        // High fill: skip in the macro build, plain pair otherwise.
        fifo_rd_num = 60;
        idle_cycle();
        idle_cycle();
        request(1'b0);
        idle_cycle();
        idle_cycle();

        // Enable drop during POP_L: pair completes, then idle.
        fifo_rd_num = 40;
        request(1'b1);
        idle_cycle();
        idle_cycle();

        // Reset during SETTLE1.
        enable = 1'b1;
        idle_cycle();
        idle_cycle();
        idle_cycle();
        sample_req = 1'b1;
        @(negedge RdClock);
        sample_req = 1'b0;
        @(negedge RdClock);
        RPReset = 1'b1;
        #1;
        check("mid_rst_rd_en", fifo_rd_en, 1'b0);
        check("mid_rst_valid", sample_valid, 1'b0);
        check("mid_rst_playing", playing, 1'b0);
        check("mid_rst_left", left_data, '0);
        check("mid_rst_right", right_data, '0);
        check("mid_rst_ucnt", underrun_cnt, '0);
        mode      = 0;
        exp_under = 0;
        exp_skip  = 0;
        @(negedge RdClock);
        check("mid_rst_hold_valid", sample_valid, 1'b0);
        @(negedge RdClock);
        RPReset = 1'b0;
        $display("[TB] reset mid-pair released");
        fifo_rd_num = 10;
        idle_cycle();
        idle_cycle();
        request(1'b0);
        fifo_rd_num = 40;
        idle_cycle();
        idle_cycle();

        // Drive the underrun counter into saturation.
        for (int n = 0; n < CNT_MAX + 2; n++) begin
            fifo_rd_num = 40;
            idle_cycle();
            idle_cycle();
            fifo_rd_num = 1;
            request(1'b0);
        end

        // Randomized requests, fill levels and enable toggles.
        for (int n = 0; n < 40; n++) begin
            for (int g = 0; g < int'($urandom_range(2, 4)); g++) begin
                fifo_rd_num = (ASIZE+1)'($urandom_range(0, 63));
                if ($urandom_range(0, 9) == 0) enable = ~enable;
                idle_cycle();
            end
            fifo_rd_num = (ASIZE+1)'($urandom_range(0, 63));
            request($urandom_range(0, 5) == 0);
        end
        idle_cycle();
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
